// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing engine: pixel-enable divider, h/v counters, registered sync/blank/coords/RGB.
// Optional test-pattern generator enabled by defining VGA_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PX_DIV   = 4,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int COLOR_W  = 4,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W     = $clog2(H_TOTAL),
    localparam int Y_W     = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               i_sclr_n,
    input  logic [COLOR_W-1:0] i_red,
    input  logic [COLOR_W-1:0] i_green,
    input  logic [COLOR_W-1:0] i_blue,
    input  logic [1:0]         i_mode,
    output logic               o_px_en,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic               o_active,
    output logic               o_frame_start,
    output logic               o_vga_hsync,
    output logic               o_vga_vsync,
    output logic [COLOR_W-1:0] o_vga_red,
    output logic [COLOR_W-1:0] o_vga_green,
    output logic [COLOR_W-1:0] o_vga_blue
);

    localparam int DIV_W = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PX_DIV - 1);
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SS   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SE   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SS   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SE   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic H_ASSERT = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_ASSERT = (V_POL != 0) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0]   div_r;
    logic [X_W-1:0]     hcnt_r;
    logic [Y_W-1:0]     vcnt_r;
    logic               px_en_s;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               active_s;
    logic               frame_edge_s;
    logic               hsync_s;
    logic               vsync_s;
    logic [COLOR_W-1:0] red_s;
    logic [COLOR_W-1:0] green_s;
    logic [COLOR_W-1:0] blue_s;

    // Decode the current counter position into pixel timing signals.
    always_comb begin
        px_en_s      = (div_r == DIV_LAST);
        h_wrap_s     = (hcnt_r == H_LAST);
        v_wrap_s     = (vcnt_r == V_LAST);
        active_s     = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
        frame_edge_s = (hcnt_r == '0) && (vcnt_r == '0);
        if ((hcnt_r >= H_SS) && (hcnt_r < H_SE)) begin
            hsync_s = H_ASSERT;
        end else begin
            hsync_s = ~H_ASSERT;
        end
        if ((vcnt_r >= V_SS) && (vcnt_r < V_SE)) begin
            vsync_s = V_ASSERT;
        end else begin
            vsync_s = ~V_ASSERT;
        end
    end

    // Pixel divider and horizontal/vertical position counters.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            div_r  <= '0;
            hcnt_r <= '0;
            vcnt_r <= '0;
        end else if (px_en_s) begin
            div_r <= '0;
            if (h_wrap_s) begin
                hcnt_r <= '0;
                if (v_wrap_s) begin
                    vcnt_r <= '0;
                end else begin
                    vcnt_r <= vcnt_r + Y_W'(1'b1);
                end
            end else begin
                hcnt_r <= hcnt_r + X_W'(1'b1);
                vcnt_r <= vcnt_r;
            end
        end else begin
            div_r  <= div_r + DIV_W'(1'b1);
            hcnt_r <= hcnt_r;
            vcnt_r <= vcnt_r;
        end
    end

`ifdef VGA_PATTERN_EN
    localparam int BAR_W_I = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
    localparam logic [X_W-1:0] BAR_W = X_W'(BAR_W_I);

    logic [1:0] mode_r;
    logic [1:0] mode_s;
    logic [2:0] bar_c_s;
    logic       chk_s;
    logic [COLOR_W-1:0] grad_s;

    // Bar index -> {R,G,B} on/off: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic x_bit3(input logic [X_W-1:0] v);
        return (v & X_W'(32'd8)) != '0;
    endfunction

    function automatic logic y_bit3(input logic [Y_W-1:0] v);
        return (v & Y_W'(32'd8)) != '0;
    endfunction

    // Mode is latched at (0,0); the first pixel of a frame already uses the new mode.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            mode_r <= 2'd0;
        end else if (px_en_s && frame_edge_s) begin
            mode_r <= i_mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Pattern generator colour selection for the current pixel.
    always_comb begin
        if (frame_edge_s) begin
            mode_s = i_mode;
        end else begin
            mode_s = mode_r;
        end
        bar_c_s = bar_color(3'(hcnt_r / BAR_W));
        chk_s   = x_bit3(hcnt_r) ^ y_bit3(vcnt_r);
        grad_s  = COLOR_W'(hcnt_r >> 2);
        red_s   = '0;
        green_s = '0;
        blue_s  = '0;
        if (active_s) begin
            case (mode_s)
                2'd0: begin
                    red_s   = i_red;
                    green_s = i_green;
                    blue_s  = i_blue;
                end
                2'd1: begin
                    red_s   = {COLOR_W{bar_c_s[2]}};
                    green_s = {COLOR_W{bar_c_s[1]}};
                    blue_s  = {COLOR_W{bar_c_s[0]}};
                end
                2'd2: begin
                    red_s   = {COLOR_W{chk_s}};
                    green_s = {COLOR_W{chk_s}};
                    blue_s  = {COLOR_W{chk_s}};
                end
                2'd3: begin
                    red_s   = grad_s;
                    green_s = grad_s;
                    blue_s  = grad_s;
                end
                default: begin
                    red_s   = i_red;
                    green_s = i_green;
                    blue_s  = i_blue;
                end
            endcase
        end else begin
            red_s   = '0;
            green_s = '0;
            blue_s  = '0;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = ^i_mode;

    // External colour passes through only inside the visible area.
    always_comb begin
        if (active_s) begin
            red_s   = i_red;
            green_s = i_green;
            blue_s  = i_blue;
        end else begin
            red_s   = '0;
            green_s = '0;
            blue_s  = '0;
        end
    end
`endif

    // Output stage: all outputs update together on pixel-enable clocks, one pixel behind the counters.
    always_ff @(posedge clk or negedge i_sclr_n) begin
        if (!i_sclr_n) begin
            o_px_en       <= 1'b0;
            o_frame_start <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_active      <= 1'b0;
            o_vga_hsync   <= ~H_ASSERT;
            o_vga_vsync   <= ~V_ASSERT;
            o_vga_red     <= '0;
            o_vga_green   <= '0;
            o_vga_blue    <= '0;
        end else begin
            o_px_en       <= px_en_s;
            o_frame_start <= px_en_s && frame_edge_s;
            if (px_en_s) begin
                o_x         <= hcnt_r;
                o_y         <= vcnt_r;
                o_active    <= active_s;
                o_vga_hsync <= hsync_s;
                o_vga_vsync <= vsync_s;
                o_vga_red   <= red_s;
                o_vga_green <= green_s;
                o_vga_blue  <= blue_s;
            end else begin
                o_x         <= o_x;
                o_y         <= o_y;
                o_active    <= o_active;
                o_vga_hsync <= o_vga_hsync;
                o_vga_vsync <= o_vga_vsync;
                o_vga_red   <= o_vga_red;
                o_vga_green <= o_vga_green;
                o_vga_blue  <= o_vga_blue;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (24x8 total, 16x4 visible, 2 clk/px).
// Stimulus pushes the expected pixel per issued input set; a negedge monitor pops on every o_px_en.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int DIV = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_PX = HT * VT;
    localparam logic HP = 1'b1;
    localparam logic VP = 1'b0;

    typedef struct packed {
        logic [4:0]  x;
        logic [2:0]  y;
        logic        act;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_sclr_n;
    logic [3:0] i_red, i_green, i_blue;
    logic [1:0] i_mode;
    logic       o_px_en, o_active, o_frame_start, o_vga_hsync, o_vga_vsync;
    logic [4:0] o_x;
    logic [2:0] o_y;
    logic [3:0] o_vga_red, o_vga_green, o_vga_blue;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, last_fs = -1, hs_run = 0, vs_run = 0;
    logic [1:0] mode_lat = 2'd0;
    logic [11:0] rgb_tab [8] = '{12'hF0A, 12'h123, 12'h5A5, 12'hFFF,
                                 12'h000, 12'h9C3, 12'h7E1, 12'h0F0};
    logic [1:0]  mode_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                 3'b101, 3'b100, 3'b001, 3'b000};

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PX_DIV(DIV), .H_POL(1), .V_POL(0), .COLOR_W(4)
    ) dut (
        .clk(clk), .i_sclr_n(i_sclr_n),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_mode(i_mode),
        .o_px_en(o_px_en), .o_x(o_x), .o_y(o_y), .o_active(o_active),
        .o_frame_start(o_frame_start), .o_vga_hsync(o_vga_hsync), .o_vga_vsync(o_vga_vsync),
        .o_vga_red(o_vga_red), .o_vga_green(o_vga_green), .o_vga_blue(o_vga_blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input logic [11:0] ext,
                                   input logic [1:0] mode);
        exp_t e;
        logic [2:0] c;
        logic [3:0] g;
        e.x   = 5'(x);
        e.y   = 3'(y);
        e.act = (x < HA) && (y < VA);
        e.hs  = (x >= HA + HF && x < HA + HF + HS) ? HP : ~HP;
        e.vs  = (y >= VA + VF && y < VA + VF + VS) ? VP : ~VP;
        e.fs  = (x == 0) && (y == 0);
        e.rgb = 12'h000;
        if (e.act) begin
`ifdef VGA_PATTERN_EN
            case (mode)
                2'd1: begin
                    c = bar_tab[x / (HA / 8)];
                    e.rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
                end
                2'd2: e.rgb = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'hFFF : 12'h000;
                2'd3: begin
                    g = 4'((x >> 2) & 15);
                    e.rgb = {g, g, g};
                end
                default: e.rgb = ext;
            endcase
`else
            e.rgb = ext;
`endif
        end
        return e;
    endfunction

    task automatic issue(input int k);
        int x, y;
        logic [11:0] rgb;
        x = k % HT;
        y = (k / HT) % VT;
        i_mode = mode_tab[((k + FRAME_PX / 2) / FRAME_PX) % 4];
        rgb = rgb_tab[k % 8];
        {i_red, i_green, i_blue} = rgb;
        if (x == 0 && y == 0) mode_lat = i_mode;
        q.push_back(model(x, y, rgb, mode_lat));
    endtask

    task automatic wait_px(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (o_px_en) begin
                ok = 1'b1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL px_en_timeout: no o_px_en within %0d clks", 10 * DIV);
    endtask

    task automatic check_reset(input string name);
        chk(name, 32'({o_px_en, o_x, o_y, o_active, o_frame_start, o_vga_hsync, o_vga_vsync,
                       o_vga_red, o_vga_green, o_vga_blue}),
            32'({1'b0, 5'd0, 3'd0, 1'b0, 1'b0, ~HP, ~VP, 12'h000}));
    endtask

    task automatic run_from_reset(input int n_px);
        bit ok;
        @(negedge clk);
        issue(0);
        i_sclr_n = 1'b1;
        for (int i = 1; i <= DIV; i++) begin
            @(posedge clk);
            #1;
            chk("px_en_latency", 32'(o_px_en), 32'(i == DIV));
        end
        for (int k = 1; k < n_px; k++) begin
            wait_px(ok);
            if (!ok) break;
            issue(k);
        end
    endtask

    // Monitor: pops the scoreboard on every presented pixel and checks sync widths and frame period.
    always @(negedge clk) begin
        exp_t e;
        if (!i_sclr_n) begin
            cyc = 0; last_fs = -1; hs_run = 0; vs_run = 0;
        end else begin
            cyc++;
            if (o_px_en) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: x=%0d y=%0d with empty scoreboard", o_x, o_y);
                end else begin
                    e = q.pop_front();
                    chk("pixel", 32'({o_x, o_y, o_active, o_vga_hsync, o_vga_vsync, o_frame_start,
                                      o_vga_red, o_vga_green, o_vga_blue}), 32'(e));
                end
                if (o_frame_start) begin
                    if (last_fs >= 0) chk("frame_period_clks", 32'(cyc - last_fs), 32'(FRAME_PX * DIV));
                    last_fs = cyc;
                end
            end
            if (o_vga_hsync == HP) hs_run++;
            else if (hs_run > 0) begin
                chk("hsync_width_clks", 32'(hs_run), 32'(HS * DIV));
                hs_run = 0;
            end
            if (o_vga_vsync == VP) vs_run++;
            else if (vs_run > 0) begin
                chk("vsync_width_clks", 32'(vs_run), 32'(VS * HT * DIV));
                vs_run = 0;
            end
        end
    end

    initial begin
        i_sclr_n = 1'b0;
        i_red = 4'd0; i_green = 4'd0; i_blue = 4'd0; i_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_initial");

        run_from_reset(2 * FRAME_PX + 50);
        @(posedge clk);
        #2;
        i_sclr_n = 1'b0;
        q.delete();
        #1;
        check_reset("reset_midframe_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_held");

        run_from_reset(2 * FRAME_PX + 10);
        repeat (DIV) @(negedge clk);
        @(posedge clk);
        #2;
        i_sclr_n = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
